// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and next-pc select types for the fetch controller
package fetch_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_RUN    = RUN,
    ST_HALTED = HALTED
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD     = 2'd0,
    NPC_INC      = 2'd1,
    NPC_REDIRECT = 2'd2,
    NPC_VECTOR   = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - next fetch word index selection with modulo-length increment
module next_pc_logic
  import fetch_pkg::*;
#(
  parameter int              length       = 256,
  parameter int              AW           = $clog2(length),
  parameter logic [AW-1:0]   reset_vector = '0
) (
  input  npc_sel_e          sel,
  input  logic [AW-1:0]     pc,
  input  logic [AW-1:0]     redirect_target,
  output logic [AW-1:0]     next_pc,
  output logic              wrap
);

  localparam logic [AW-1:0] LAST_PC = AW'(length - 1);

  // Select the next pc; wrap is only reported for a sequential step past the last word
  always_comb begin
    next_pc = pc;
    wrap    = 1'b0;
    case (sel)
      NPC_HOLD:     next_pc = pc;
      NPC_INC: begin
        if (pc == LAST_PC) begin
          next_pc = '0;
          wrap    = 1'b1;
        end else begin
          next_pc = pc + AW'(1);
        end
      end
      NPC_REDIRECT: next_pc = redirect_target;
      NPC_VECTOR:   next_pc = reset_vector;
      default:      next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-issue instruction fetch controller with stall, redirect and halt
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                          size         = 32,
  parameter int                          length       = 256,
  parameter logic [$clog2(length)-1:0]   reset_vector = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           halt,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [$clog2(length)-1:0]      redirect_target,
  input  logic [size-1:0]                imem_instruction,
  output logic [$clog2(length)-1:0]      imem_pc,
  output logic [size-1:0]                inst,
  output logic [$clog2(length)-1:0]      inst_pc,
  output logic                           inst_valid,
  output logic                           busy,
  output logic                           wrap_flag
);

  localparam int AW = $clog2(length);

  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [size-1:0] inst_q, inst_d;
  logic [AW-1:0]  inst_pc_q, inst_pc_d;
  logic           inst_valid_q, inst_valid_d;
  logic           wrap_q, wrap_d;
  npc_sel_e       npc_sel;
  logic           npc_wrap;

  next_pc_logic #(
    .length       (length),
    .AW           (AW),
    .reset_vector (reset_vector)
  ) u_next_pc (
    .sel             (npc_sel),
    .pc              (pc_q),
    .redirect_target (redirect_target),
    .next_pc         (pc_d),
    .wrap            (npc_wrap)
  );

  // Next state and datapath control; in RUN the order is halt > redirect > hold > advance
  always_comb begin
    state_d      = state_q;
    npc_sel      = NPC_HOLD;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      ST_IDLE: begin
        npc_sel      = NPC_VECTOR;
        inst_valid_d = 1'b0;
        if (halt) begin
          state_d = ST_HALTED;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt) begin
          // Whatever is in the output register is dropped, stalled or not
          state_d      = ST_HALTED;
          inst_valid_d = 1'b0;
        end else if (redirect_valid) begin
          // One-bubble flush: the wrong-path instruction is discarded even under stall
          npc_sel      = NPC_REDIRECT;
          inst_valid_d = 1'b0;
        end else if (inst_valid_q && stall) begin
          npc_sel = NPC_HOLD;
        end else begin
          npc_sel      = NPC_INC;
          inst_d       = imem_instruction;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
        end
      end
      ST_HALTED: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d      = ST_IDLE;
        inst_valid_d = 1'b0;
      end
    endcase
    wrap_d = wrap_q | ((npc_sel == NPC_INC) & npc_wrap);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= reset_vector;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign imem_pc    = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign busy       = (state_q == ST_RUN);
  assign wrap_flag  = wrap_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [31:0] imem_instruction;
  logic [7:0]  imem_pc;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        busy;
  logic        wrap_flag;

  int n_compared;
  int n_mismatched;

  fetch_controller #(
    .size         (32),
    .length       (256),
    .reset_vector (8'h00)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .halt             (halt),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_instruction (imem_instruction),
    .imem_pc          (imem_pc),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_valid       (inst_valid),
    .busy             (busy),
    .wrap_flag        (wrap_flag)
  );

  // Instruction memory preloaded with mem[i] = 32'h1000_0000 + i
  assign imem_instruction = 32'h1000_0000 + {24'h0, imem_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    reset           = 1'b1;
    start           = 1'b0;
    halt            = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'h00;
    step();
    step();
    check_value("rst_imem_pc", 32'(imem_pc), 32'h0);
    check_value("rst_inst", inst, 32'h0);
    check_value("rst_inst_pc", 32'(inst_pc), 32'h0);
    check_value("rst_valid", 32'(inst_valid), 32'h0);
    check_value("rst_busy", 32'(busy), 32'h0);
    check_value("rst_wrap", 32'(wrap_flag), 32'h0);

    // Start in cycle 0
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_value("c1_imem_pc", 32'(imem_pc), 32'h0);
    check_value("c1_valid", 32'(inst_valid), 32'h0);
    check_value("c1_busy", 32'(busy), 32'h1);
    step();
    check_value("c2_inst", inst, 32'h1000_0000);
    check_value("c2_inst_pc", 32'(inst_pc), 32'h0);
    check_value("c2_valid", 32'(inst_valid), 32'h1);
    step();
    check_value("c3_inst_pc", 32'(inst_pc), 32'h1);

    // Advance to inst_pc = 5 then stall three cycles
    for (int i = 0; i < 4; i++) step();
    check_value("pre_stall_inst_pc", 32'(inst_pc), 32'h5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("stall_inst", inst, 32'h1000_0005);
      check_value("stall_imem_pc", 32'(imem_pc), 32'h6);
      check_value("stall_inst_pc", 32'(inst_pc), 32'h5);
    end
    stall = 1'b0;
    step();
    check_value("release_inst_pc", 32'(inst_pc), 32'h6);

    // Redirect to 0x40 under stall while inst_pc = 10
    for (int i = 0; i < 4; i++) step();
    check_value("pre_redir_inst_pc", 32'(inst_pc), 32'hA);
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 8'h40;
    step();
    redirect_valid = 1'b0;
    check_value("redir_valid", 32'(inst_valid), 32'h0);
    check_value("redir_imem_pc", 32'(imem_pc), 32'h40);
    // Stall still high, but the bubble must be filled
    step();
    check_value("redir_inst", inst, 32'h1000_0040);
    check_value("redir_inst_pc", 32'(inst_pc), 32'h40);
    check_value("redir_valid2", 32'(inst_valid), 32'h1);
    step();
    check_value("redir_hold_inst_pc", 32'(inst_pc), 32'h40);
    check_value("redir_hold_imem_pc", 32'(imem_pc), 32'h41);
    stall = 1'b0;

    // Redirect near the top and run through the wrap
    redirect_valid  = 1'b1;
    redirect_target = 8'hFE;
    step();
    redirect_valid = 1'b0;
    check_value("fe_imem_pc", 32'(imem_pc), 32'hFE);
    check_value("fe_wrap", 32'(wrap_flag), 32'h0);
    step();
    check_value("seq_fe", 32'(inst_pc), 32'hFE);
    check_value("seq_fe_wrap", 32'(wrap_flag), 32'h0);
    step();
    check_value("seq_ff", 32'(inst_pc), 32'hFF);
    check_value("seq_ff_imem_pc", 32'(imem_pc), 32'h0);
    check_value("seq_ff_wrap", 32'(wrap_flag), 32'h1);
    step();
    check_value("seq_00", 32'(inst_pc), 32'h0);
    check_value("seq_00_inst", inst, 32'h1000_0000);
    check_value("seq_00_wrap", 32'(wrap_flag), 32'h1);

    // Halt together with redirect under stall
    halt            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 8'h20;
    stall           = 1'b1;
    step();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check_value("halt_valid", 32'(inst_valid), 32'h0);
    check_value("halt_busy", 32'(busy), 32'h0);
    check_value("halt_imem_pc", 32'(imem_pc), 32'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_value("halted_start_busy", 32'(busy), 32'h0);
    check_value("halted_start_valid", 32'(inst_valid), 32'h0);
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    check_value("halted_redir_imem_pc", 32'(imem_pc), 32'h1);
    check_value("halted_wrap", 32'(wrap_flag), 32'h1);

    // Reset dominates a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_value("rst2_imem_pc", 32'(imem_pc), 32'h0);
    check_value("rst2_wrap", 32'(wrap_flag), 32'h0);
    check_value("rst2_busy", 32'(busy), 32'h0);
    check_value("rst2_inst", inst, 32'h0);

    // Halt wins over start in IDLE
    reset = 1'b0;
    halt  = 1'b1;
    start = 1'b1;
    step();
    halt = 1'b0;
    step();
    start = 1'b0;
    check_value("idle_halt_busy", 32'(busy), 32'h0);
    check_value("idle_halt_valid", 32'(inst_valid), 32'h0);

    // Reset in the middle of a stalled run
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    check_value("rst3_valid", 32'(inst_valid), 32'h0);
    check_value("rst3_inst_pc", 32'(inst_pc), 32'h0);
    check_value("rst3_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
